// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage load/store engine.
// Covers FSM states, access sizes and byte-enable patterns.
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_t;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;

endpackage

// File: rtl/load_align.sv
// Selects the loaded lane from the bus word and applies
// sign or zero extension to a full 32-bit result.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] i_bus_rdata,
  input  logic [1:0]  i_lane,
  input  size_t       i_size,
  input  logic        i_ext,
  output logic [31:0] o_data
);

  logic [7:0]  w_b;
  logic [15:0] w_h;

  always_comb begin
    w_b = i_bus_rdata[7:0];
    case (i_lane)
      2'd0: w_b = i_bus_rdata[7:0];
      2'd1: w_b = i_bus_rdata[15:8];
      2'd2: w_b = i_bus_rdata[23:16];
      2'd3: w_b = i_bus_rdata[31:24];
      default: w_b = i_bus_rdata[7:0];
    endcase
  end

  assign w_h = i_lane[1] ? i_bus_rdata[31:16]
                         : i_bus_rdata[15:0];

  always_comb begin
    o_data = i_bus_rdata;
    case (i_size)
      SZ_BYTE: o_data = {{24{i_ext & w_b[7]}}, w_b};
      SZ_HALF: o_data = {{16{i_ext & w_h[15]}}, w_h};
      default: o_data = i_bus_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: turns pipeline memory controls
// into a req/ack word bus transaction and stalls until done.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_half,
  input  logic              mem_byte,
  input  logic              mem_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              misalign,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  state_t      r_state;
  size_t       r_size;
  logic [1:0]  r_lane;
  logic        r_ext;

  size_t       w_size;
  logic        w_access;
  logic        w_misal;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ld;

  assign w_size = mem_byte ? SZ_BYTE :
                  mem_half ? SZ_HALF : SZ_WORD;

  assign w_access = mem_read | mem_write;

  assign w_misal =
    ((w_size == SZ_HALF) & addr[0]) |
    ((w_size == SZ_WORD) & (addr[1:0] != 2'b00));

  always_comb begin
    w_be    = BE_WORD;
    w_wdata = wdata;
    case (w_size)
      SZ_BYTE: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        w_be    = addr[1] ? BE_HI : BE_LO;
        w_wdata = {2{wdata[15:0]}};
      end
      default: begin
        w_be    = BE_WORD;
        w_wdata = wdata;
      end
    endcase
  end

  // Held through the ack cycle so the pipeline advances only in DONE
  assign stall = ~rst &
    (((r_state == S_IDLE) & w_access & ~w_misal) |
     (r_state == S_BUS));

  load_align u_align (
    .i_bus_rdata (bus_rdata),
    .i_lane      (r_lane),
    .i_size      (r_size),
    .i_ext       (r_ext),
    .o_data      (w_ld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_size      <= SZ_WORD;
      r_lane      <= 2'b00;
      r_ext       <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= 4'b0000;
      bus_wdata   <= 32'h0;
      rdata       <= 32'h0;
      rdata_valid <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      misalign    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            if (w_misal) begin
              misalign <= 1'b1;
            end else begin
              bus_req   <= 1'b1;
              bus_we    <= mem_write;
              bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
              bus_be    <= w_be;
              bus_wdata <= w_wdata;
              r_lane    <= addr[1:0];
              r_size    <= w_size;
              r_ext     <= mem_ext;
              r_state   <= S_BUS;
            end
          end
        end
        S_BUS: begin
          if (bus_ack) begin
            bus_req     <= 1'b0;
            rdata_valid <= 1'b1;
            if (!bus_we) rdata <= w_ld;
            r_state     <= S_DONE;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; a monitor pops expected
// rdata/misalign events from a scoreboard queue as they appear.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic        mem_half;
  logic        mem_byte;
  logic        mem_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        misalign;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks;
  int failures;

  typedef struct packed {
    logic        is_mis;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_half    (mem_half),
    .mem_byte    (mem_byte),
    .mem_ext     (mem_ext),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .misalign    (misalign),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rdata_valid === 1'b1 || misalign === 1'b1) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: rv=%b mis=%b rdata=%h",
                 rdata_valid, misalign, rdata);
      end else begin
        e = sb.pop_front();
        if (e.is_mis) begin
          if (misalign !== 1'b1 || rdata_valid !== 1'b0) begin
            failures++;
            $display("FAIL misalign_evt: mis=%b rv=%b expected mis=1 rv=0",
                     misalign, rdata_valid);
          end
        end else if (rdata_valid !== 1'b1 || misalign !== 1'b0 ||
                     rdata !== e.data) begin
          failures++;
          $display("FAIL rdata_evt: rv=%b mis=%b rdata=%h expected rv=1 rdata=%h",
                   rdata_valid, misalign, rdata, e.data);
        end
      end
    end
  end

  task automatic clear_in();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_half  = 1'b0;
    mem_byte  = 1'b0;
    mem_ext   = 1'b0;
    addr      = 32'h0;
    wdata     = 32'h0;
  endtask

  task automatic access(input logic        rd,
                        input logic        wr,
                        input logic        hf,
                        input logic        by,
                        input logic        ex,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [31:0] brd,
                        input int          dly,
                        input logic [31:0] e_addr,
                        input logic [3:0]  e_be,
                        input logic [31:0] e_wd,
                        input logic        mis,
                        input logic [31:0] e_rd);
    int nst;
    exp_t e;
    nst = 0;
    mem_read  = rd;
    mem_write = wr;
    mem_half  = hf;
    mem_byte  = by;
    mem_ext   = ex;
    addr      = a;
    wdata     = wd;
    bus_ack   = 1'b0;
    e.is_mis  = mis;
    e.data    = e_rd;
    sb.push_back(e);
    @(negedge clk);
    if (stall) nst++;
    if (mis) begin
      chk("mis_stall", {31'b0, stall}, 32'd0);
      @(posedge clk); #1;
      clear_in();
      chk("mis_req", {31'b0, bus_req}, 32'd0);
      @(negedge clk);
      chk("mis_req2", {31'b0, bus_req}, 32'd0);
      chk("mis_stall2", {31'b0, stall}, 32'd0);
      @(posedge clk); #1;
      chk("mis_pulse_end", {31'b0, misalign}, 32'd0);
      return;
    end
    for (int c = 1; c <= dly; c++) begin
      @(posedge clk); #1;
      chk("bus_req", {31'b0, bus_req}, 32'd1);
      chk("bus_we", {31'b0, bus_we}, {31'b0, wr});
      chk("bus_addr", bus_addr, e_addr);
      chk("bus_be", {28'b0, bus_be}, {28'b0, e_be});
      if (wr) chk("bus_wdata", bus_wdata, e_wd);
      if (c == dly) begin
        bus_ack   = 1'b1;
        bus_rdata = brd;
      end
      @(negedge clk);
      if (stall) nst++;
    end
    @(posedge clk); #1;
    bus_ack   = 1'b0;
    bus_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("done_stall", {31'b0, stall}, 32'd0);
    chk("done_req", {31'b0, bus_req}, 32'd0);
    chk("stall_cycles", nst, dly + 1);
    @(posedge clk); #1;
    clear_in();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    clear_in();
    mem_read  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_req", {31'b0, bus_req}, 32'd0);
    chk("rst_be", {28'b0, bus_be}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rv", {30'b0, rdata_valid, misalign}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_in();
    @(posedge clk); #1;

    // sb 0x1003
    access(0,1,0,1,0, 32'h1003, 32'h000000A5, 32'h0, 1,
           32'h1000, 4'b1000, 32'hA5A5A5A5, 0, 32'h0);
    // lb / lbu 0x2001
    access(1,0,0,1,1, 32'h2001, 32'h0, 32'h12348056, 1,
           32'h2000, 4'b0010, 32'h0, 0, 32'hFFFFFF80);
    access(1,0,0,1,0, 32'h2001, 32'h0, 32'h12348056, 3,
           32'h2000, 4'b0010, 32'h0, 0, 32'h00000080);
    // lh / lhu 0x2002, lw 0x2000
    access(1,0,1,0,1, 32'h2002, 32'h0, 32'h80017FFF, 1,
           32'h2000, 4'b1100, 32'h0, 0, 32'hFFFF8001);
    access(1,0,1,0,0, 32'h2002, 32'h0, 32'h80017FFF, 2,
           32'h2000, 4'b1100, 32'h0, 0, 32'h00008001);
    access(1,0,0,0,1, 32'h2000, 32'h0, 32'h80017FFF, 1,
           32'h2000, 4'b1111, 32'h0, 0, 32'h80017FFF);
    // misaligned lw / lh
    access(1,0,0,0,1, 32'h3002, 32'h0, 32'h0, 0,
           32'h0, 4'b0, 32'h0, 1, 32'h0);
    access(1,0,1,0,1, 32'h3001, 32'h0, 32'h0, 0,
           32'h0, 4'b0, 32'h0, 1, 32'h0);
    // sw with 5-cycle ack delay; rdata keeps last load
    access(0,1,0,0,0, 32'h4000, 32'hDEADBEEF, 32'h0, 5,
           32'h4000, 4'b1111, 32'hDEADBEEF, 0, 32'h80017FFF);
    // sh upper half; mem_write beats mem_read, byte beats half
    access(1,1,1,0,0, 32'h4002, 32'h1234BEEF, 32'h0, 2,
           32'h4000, 4'b1100, 32'hBEEFBEEF, 0, 32'h80017FFF);
    access(1,0,1,1,1, 32'h5003, 32'h0, 32'h7F000000, 1,
           32'h5000, 4'b1000, 32'h0, 0, 32'h0000007F);

    // reset in second BUS cycle, late ack ignored
    mem_read = 1'b1;
    addr     = 32'h6000;
    @(posedge clk); #1;
    chk("abort_req1", {31'b0, bus_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_in();
    chk("abort_req", {31'b0, bus_req}, 32'd0);
    chk("abort_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    bus_ack   = 1'b1;
    bus_rdata = 32'h11111111;
    @(negedge clk);
    chk("abort_ack_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("abort_ack_req", {31'b0, bus_req}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_rdata", rdata, 32'h0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage load/store engine for the pipelined MIPS core. It consumes the memory-control signals produced by the decode controller (MemWrite, Memrhalf, Memrbyte, MemExt, plus a load strobe). It turns each access into a word-wide bus transaction with byte enables, using a req/ack handshake. For loads, it returns the lane-extracted, sign- or zero-extended result and stalls the pipeline while the access is outstanding.

Parameters:
ADDR_W, 32, byte-address width on the pipeline and bus sides.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
mem_read  input  1  load in MEM stage (lw/lh/lhu/lb/lbu)
mem_write  input  1  store in MEM stage (MemWrite)
mem_half  input  1  halfword access (Memrhalf)
mem_byte  input  1  byte access (Memrbyte)
mem_ext  input  1  sign-extend load result (MemExt); 0 = zero-extend
addr  input  ADDR_W  byte address from ALU
wdata  input  32  store data (rt value)
stall  output  1  hold IF/ID/EX/MEM registers
rdata  output  32  extended load result
rdata_valid  output  1  one-cycle pulse, rdata valid
misalign  output  1  one-cycle pulse, address-alignment exception
bus_req  output  1  bus request
bus_we  output  1  bus write
bus_addr  output  ADDR_W  word-aligned address, addr[1:0] = 0
bus_be  output  4  byte enables, bit i = byte lane i
bus_wdata  output  32  lane-replicated store data
bus_ack  input  1  bus completion, valid only while bus_req = 1
bus_rdata  input  32  read word, sampled in the ack cycle

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: state IDLE. bus_req, bus_we, bus_addr, bus_be, bus_wdata, rdata, rdata_valid and misalign are all 0. stall is 0 while rst = 1.
- Little-endian lane mapping:
  - Byte: be = 1 << addr[1:0]; wdata is replicated as {4{wdata[7:0]}}.
  - Half: be = 0011 if addr[1] = 0, else 1100; wdata is replicated as {2{wdata[15:0]}}.
  - Word: be = 1111; wdata is passed through.
- Priority on conflicting controls: mem_byte wins over mem_half, and mem_write wins over mem_read.
- Alignment rule: a halfword with addr[0] = 1 is misaligned; a word with addr[1:0] != 0 is misaligned. A misaligned access:
  - pulses misalign for one cycle (registered, visible the cycle after the access is presented);
  - issues no bus_req and keeps stall = 0;
  - leaves the state in IDLE.
- FSM IDLE / BUS / DONE:
  - IDLE: an aligned access (mem_read or mem_write) makes stall = 1 combinationally in the same cycle. On the clock edge the unit registers bus_addr, bus_be, bus_we and bus_wdata, sets bus_req = 1, latches the size/ext/lane info, and moves to BUS.
  - BUS: stall = 1 while bus_ack = 0, and also in the ack cycle. All bus_* outputs are held stable until the ack. On bus_ack: bus_req drops, the loaded lane is captured and extended into rdata (stores leave rdata unchanged), and the state moves to DONE.
  - DONE: stall = 0 and rdata_valid = 1 for this one cycle; the pipeline advances on this edge. The next state is always IDLE; no new request is accepted in DONE.
- Latency: minimum 3 cycles (IDLE, BUS with immediate ack, DONE). Each extra wait cycle adds 1.
- Load extension:
  - byte: rdata = {24{mem_ext & b[7]}, b}
  - half: rdata = {16{mem_ext & h[15]}, h}
  - word: pass-through
- bus_ack outside BUS is ignored.
- Reset mid-operation: rst in BUS returns to IDLE on that edge and drops bus_req. Any later ack for the abandoned request is ignored.

Decomposition:
- Shared package mem_pkg:
  - state encoding (IDLE/BUS/DONE);
  - size codes (SZ_BYTE, SZ_HALF, SZ_WORD);
  - byte-enable constants (BE_WORD = 4'b1111, BE_LO = 4'b0011, BE_HI = 4'b1100).
- One combinational sub-module, load_align, holds the lane select and sign/zero extension (inputs: bus_rdata, lane, size, ext).
- Store-lane generation and the FSM stay in mem_access_unit.

Test Plan:
1. sb, addr = 0x1003, wdata = 0x000000A5, ack in first BUS cycle -> bus_addr = 0x1000, bus_be = 1000, bus_wdata = 0xA5A5A5A5, bus_we = 1; stall high for 2 cycles then low in DONE.
2. lb, addr = 0x2001, bus_rdata = 0x12348056 -> rdata = 0xFFFFFF80 with rdata_valid pulse; the same access as lbu (mem_ext = 0) -> rdata = 0x00000080.
3. lh, addr = 0x2002, bus_rdata = 0x80017FFF -> bus_be = 1100, rdata = 0xFFFF8001; lhu -> rdata = 0x00008001; lw at 0x2000 -> rdata = 0x80017FFF.
4. lw at addr = 0x3002, or lh at 0x3001 -> misalign pulse for 1 cycle, bus_req never asserted, stall = 0, state stays IDLE.
5. sw, addr = 0x4000, ack delayed 5 cycles -> stall high for 6 consecutive cycles; bus_addr, bus_be and bus_wdata unchanged throughout; exactly one DONE cycle.
6. rst asserted in the second BUS cycle, bus_ack arrives 2 cycles later -> bus_req = 0 and stall = 0 right after the reset edge, ack ignored, no rdata_valid.
